// File: rtl/trav_arb.sv
// Traversal arbiter: three buffered request ports feed one registered output stage.
// Ports 0/1 (in-flight rays) share round-robin priority; port 2 (new rays) only when both are idle.
package trav_arb_pkg;
    typedef logic [31:0] tarb_t_t;
endpackage

module trav_arb #(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = $bits(trav_arb_pkg::tarb_t_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss_to_tarb_valid0,
    input  logic [DATA_W-1:0] ss_to_tarb_data0,
    output logic              ss_to_tarb_stall0,
    input  logic              ss_to_tarb_valid1,
    input  logic [DATA_W-1:0] ss_to_tarb_data1,
    output logic              ss_to_tarb_stall1,
    input  logic              raystore_to_tarb_valid,
    input  logic [DATA_W-1:0] raystore_to_tarb_data,
    output logic              raystore_to_tarb_stall,
    output logic              tarb_to_trav_valid,
    output logic [DATA_W-1:0] tarb_to_trav_data,
    output logic [1:0]        tarb_to_trav_src,
    input  logic              tarb_to_trav_stall
);
    localparam int NP = 3;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic [NP-1:0]     in_valid_s;
    logic [DATA_W-1:0] in_data_s [NP];
    logic [NP-1:0]     push_s;
    logic [NP-1:0]     pop_s;
    logic [NP-1:0]     ne_s;
    logic [DATA_W-1:0] head_s [NP];

    logic [DATA_W-1:0] mem_q  [NP][FIFO_DEPTH];
    logic [AW-1:0]     wptr_q [NP];
    logic [AW-1:0]     rptr_q [NP];
    logic [AW:0]       cnt_q  [NP];
    logic [AW:0]       cnt_d  [NP];
    logic [NP-1:0]     full_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_src_q;
    logic              rr_q;

    logic              load_s;
    logic              grant_vld_s;
    logic [1:0]        grant_s;
    logic [DATA_W-1:0] grant_data_s;

    assign in_valid_s   = {raystore_to_tarb_valid, ss_to_tarb_valid1, ss_to_tarb_valid0};
    assign in_data_s[0] = ss_to_tarb_data0;
    assign in_data_s[1] = ss_to_tarb_data1;
    assign in_data_s[2] = raystore_to_tarb_data;

    // Stall is a registered full flag, so acceptance never depends on the sender's valid.
    assign push_s = in_valid_s & ~full_q;
    assign load_s = ~out_valid_q | ~tarb_to_trav_stall;

    // Per-FIFO occupancy, emptiness and head-of-queue decode.
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            cnt_d[p]  = cnt_q[p] + (AW+1)'(push_s[p]) - (AW+1)'(pop_s[p]);
            ne_s[p]   = (cnt_q[p] != '0);
            head_s[p] = mem_q[p][rptr_q[p]];
        end
    end

    // Grant selection: ports 0/1 round-robin on rr_q, port 2 only when both are empty.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 2'd0;
        if (ne_s[0] && ne_s[1]) begin
            grant_vld_s = 1'b1;
            grant_s     = rr_q ? 2'd1 : 2'd0;
        end else if (ne_s[0]) begin
            grant_vld_s = 1'b1;
            grant_s     = 2'd0;
        end else if (ne_s[1]) begin
            grant_vld_s = 1'b1;
            grant_s     = 2'd1;
        end else if (ne_s[2]) begin
            grant_vld_s = 1'b1;
            grant_s     = 2'd2;
        end else begin
            grant_vld_s = 1'b0;
            grant_s     = 2'd0;
        end
    end

    // Pop the granted FIFO and select its head for the output stage.
    always_comb begin
        pop_s        = 3'b000;
        grant_data_s = head_s[0];
        case (grant_s)
            2'd0:    grant_data_s = head_s[0];
            2'd1:    grant_data_s = head_s[1];
            2'd2:    grant_data_s = head_s[2];
            default: grant_data_s = head_s[0];
        endcase
        if (load_s && grant_vld_s) begin
            case (grant_s)
                2'd0:    pop_s = 3'b001;
                2'd1:    pop_s = 3'b010;
                2'd2:    pop_s = 3'b100;
                default: pop_s = 3'b000;
            endcase
        end else begin
            pop_s = 3'b000;
        end
    end

    // FIFO storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push_s[p]) begin
                mem_q[p][wptr_q[p]] <= in_data_s[p];
            end
        end
    end

    // FIFO pointers, occupancy and full flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                wptr_q[p] <= '0;
                rptr_q[p] <= '0;
                cnt_q[p]  <= '0;
            end
            full_q <= 3'b000;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push_s[p]) begin
                    wptr_q[p] <= wptr_q[p] + AW'(1'b1);
                end
                if (pop_s[p]) begin
                    rptr_q[p] <= rptr_q[p] + AW'(1'b1);
                end
                cnt_q[p]  <= cnt_d[p];
                full_q[p] <= (cnt_d[p] == FULL_CNT);
            end
        end
    end

    // Output register and round-robin pointer; a grant to port 2 leaves rr untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            rr_q        <= 1'b0;
        end else if (load_s) begin
            out_valid_q <= grant_vld_s;
            if (grant_vld_s) begin
                out_data_q <= grant_data_s;
                out_src_q  <= grant_s;
                if (grant_s == 2'd0) begin
                    rr_q <= 1'b1;
                end else if (grant_s == 2'd1) begin
                    rr_q <= 1'b0;
                end
            end
        end
    end

    assign ss_to_tarb_stall0      = full_q[0];
    assign ss_to_tarb_stall1      = full_q[1];
    assign raystore_to_tarb_stall = full_q[2];
    assign tarb_to_trav_valid     = out_valid_q;
    assign tarb_to_trav_data      = out_data_q;
    assign tarb_to_trav_src       = out_src_q;
endmodule
